oab_top: RTL and testbench

OAB_TOP -- requirements
Module: oab_top

---
 rtl/oab_pkg.sv | 25 ++
 rtl/oab_lfsr.sv | 23 ++
 rtl/oab_top.sv | 117 +++++++++++
 tb/tb_oab_top.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oab_pkg.sv
// Shared types and constants for the three-reel slot controller.
// Holds the FSM state encoding, LFSR seed/taps, and reel helper functions.
package oab_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: taps at bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam int          NUM_DIGITS = 10;

    function automatic logic [3:0] red10(input logic [3:0] v);
        return (v >= 4'd10) ? (v - 4'd10) : v;
    endfunction

    function automatic logic [7:0] sat8(input logic [15:0] v);
        return (v > 16'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/oab_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; resets to the package seed.
// Only the low 12 bits are exported, since they are all the reels consume.
module oab_lfsr
    import oab_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] rnd
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
        end
    end

    assign rnd = lfsr_q[11:0];

endmodule

// File: rtl/oab_top.sv
// Three-reel slot machine controller: lever edge detect, timed spin,
// reel evaluation and saturating payout.
//
// state | meaning
// IDLE  | waiting for a lever rise with a non-zero bet
// SPIN  | counting down; reel indices captured from the LFSR on the last cycle
// EVAL  | look up symbols in the code table and register jackpot/payout
// DONE  | hold result until the lever is released
module oab_top
    import oab_pkg::*;
#(
    parameter int SPIN_CYCLES = 8,
    parameter int PAY_TRIPLE  = 15,
    parameter int PAY_PAIR    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll,
    input  logic [3:0] bet,
    input  logic [3:0] code [NUM_DIGITS-1:0],
    output logic       jackpot,
    output logic [7:0] payout
);

    localparam logic [7:0] CNT_INIT = 8'(SPIN_CYCLES - 1);

    state_t      state;
    logic        roll_q;
    logic        rise_q;
    logic [3:0]  bet_q;
    logic [7:0]  cnt;
    logic [3:0]  idx0;
    logic [3:0]  idx1;
    logic [3:0]  idx2;
    logic [11:0] rnd;

    logic [3:0]  r0;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic        triple;
    logic        pair;
    logic [15:0] prod_triple;
    logic [15:0] prod_pair;

    oab_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .rnd (rnd)
    );

    assign r0          = code[idx0];
    assign r1          = code[idx1];
    assign r2          = code[idx2];
    assign triple      = (r0 == r1) && (r1 == r2);
    assign pair        = (r0 == r1) || (r1 == r2) || (r0 == r2);
    assign prod_triple = 16'(bet_q) * 16'(PAY_TRIPLE);
    assign prod_pair   = 16'(bet_q) * 16'(PAY_PAIR);

    // The rise is registered once more before the FSM consumes it, so the
    // result lands SPIN_CYCLES+2 edges after the edge that first sees roll high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            jackpot <= 1'b0;
            payout  <= 8'd0;
            bet_q   <= 4'd0;
            cnt     <= 8'd0;
            idx0    <= 4'd0;
            idx1    <= 4'd0;
            idx2    <= 4'd0;
            roll_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            roll_q <= roll;
            rise_q <= roll & ~roll_q;
            unique case (state)
                IDLE: begin
                    if (rise_q && (bet != 4'd0)) begin
                        bet_q   <= bet;
                        jackpot <= 1'b0;
                        payout  <= 8'd0;
                        cnt     <= CNT_INIT;
                        state   <= SPIN;
                    end
                end
                SPIN: begin
                    if (cnt == 8'd0) begin
                        idx0  <= red10(rnd[3:0]);
                        idx1  <= red10(rnd[7:4]);
                        idx2  <= red10(rnd[11:8]);
                        state <= EVAL;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                EVAL: begin
                    jackpot <= triple;
                    if (triple) begin
                        payout <= sat8(prod_triple);
                    end else if (pair) begin
                        payout <= sat8(prod_pair);
                    end else begin
                        payout <= 8'd0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (!roll) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oab_top.sv
// Scoreboard bench for oab_top: the driver predicts each spin from a reel model
// and queues expectations by cycle; a negedge monitor pops and compares them.
module tb_oab_top;
    import oab_pkg::*;

    localparam int N  = 8;
    localparam int PT = 15;
    localparam int PP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       roll = 1'b0;
    logic [3:0] bet = 4'd0;
    logic [3:0] code [9:0];
    logic       jackpot;
    logic [7:0] payout;

    oab_top #(.SPIN_CYCLES(N), .PAY_TRIPLE(PT), .PAY_PAIR(PP)) dut (
        .clk     (clk),
        .rst     (rst),
        .roll    (roll),
        .bet     (bet),
        .code    (code),
        .jackpot (jackpot),
        .payout  (payout)
    );

    always #5 clk = ~clk;

    // Edges since reset release; edge k uses LFSR value seed advanced k-1 times.
    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    typedef struct {
        int         due;
        logic       jp;
        logic [7:0] pay;
        string      name;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    logic       last_jp = 1'b0;
    logic [7:0] last_pay = 8'd0;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.due != cyc) begin
                errors++;
                $display("FAIL %s: monitor late at cycle %0d, due %0d", mon_e.name, cyc, mon_e.due);
            end else if (jackpot !== mon_e.jp || payout !== mon_e.pay) begin
                errors++;
                $display("FAIL %s @%0d: jackpot=%0b payout=%0d, expected jackpot=%0b payout=%0d",
                         mon_e.name, cyc, jackpot, payout, mon_e.jp, mon_e.pay);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int k);
        int guard = 0;
        while (cyc < k && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < k) begin
            errors++;
            $display("FAIL wait_timeout: cycle %0d, wanted %0d", cyc, k);
        end
    endtask

    function automatic logic [15:0] lfsr_at(input int k);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 1; i < k; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        return s;
    endfunction

    // Reel model: index = nibble mod 10, then count matching symbols.
    function automatic void model(input logic [3:0] b, input logic [15:0] s,
                                  input logic [3:0] cd [9:0],
                                  output logic jp, output logic [7:0] pay);
        int a0, a1, a2, mult, p;
        a0 = int'(s[3:0]) % 10;
        a1 = int'(s[7:4]) % 10;
        a2 = int'(s[11:8]) % 10;
        jp = 1'b0;
        mult = 0;
        if (cd[a0] == cd[a1] && cd[a1] == cd[a2]) begin
            jp = 1'b1;
            mult = PT;
        end else if (cd[a0] == cd[a1] || cd[a1] == cd[a2] || cd[a0] == cd[a2]) begin
            mult = PP;
        end
        p = int'(b) * mult;
        pay = (p > 255) ? 8'd255 : 8'(p);
    endfunction

    task automatic set_code_all(input logic [3:0] d);
        for (int i = 0; i < 10; i++) code[i] = d;
    endtask

    // Called at a negedge with roll low (or already high right after reset release).
    task automatic do_spin(input logic [3:0] b, input int hold, input bit chg, input bit pulse);
        int          e;
        logic [15:0] s;
        logic [3:0]  nc [9:0];
        logic        jp;
        logic [7:0]  pay;
        for (int i = 0; i < 10; i++) nc[i] = chg ? 4'($urandom_range(0, 2)) : code[i];
        bet  = b;
        roll = 1'b1;
        e    = cyc + 1;
        s    = lfsr_at(e + N + 1);
        model(b, s, nc, jp, pay);
        sb.push_back('{e + 1, 1'b0, 8'd0, "spin_clear"});
        sb.push_back('{e + N + 2, jp, pay, "spin_result"});
        for (int h = 1; h <= hold; h++) sb.push_back('{e + N + 2 + h, jp, pay, "spin_hold"});
        last_jp  = jp;
        last_pay = pay;
        wait_cyc(e + 1);
        if (chg) begin
            bet  = 4'($urandom_range(0, 15));
            code = nc;
        end
        if (pulse) begin
            wait_cyc(e + 2);
            roll = 1'b0;
            wait_cyc(e + 3);
            roll = 1'b1;
        end
        wait_cyc(e + N + 2 + hold);
        roll = 1'b0;
        wait_cyc(e + N + 3 + hold);
        check("done_to_idle", int'(dut.state), int'(IDLE));
    endtask

    task automatic bet_zero_test();
        bet  = 4'd0;
        roll = 1'b1;
        repeat (N + 4) @(negedge clk);
        check("bet0_state", int'(dut.state), int'(IDLE));
        check("bet0_jackpot", int'(jackpot), int'(last_jp));
        check("bet0_payout", int'(payout), int'(last_pay));
        roll = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int v;
        int e;
        int guard;
        set_code_all(4'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_state", int'(dut.state), int'(IDLE));
        check("rst_lfsr", int'(dut.u_lfsr.lfsr_q), 16'hACE1);
        check("rst_jackpot", int'(jackpot), 0);
        check("rst_payout", int'(payout), 0);
        rst = 1'b1;

        bet_zero_test();

        set_code_all(4'd7);
        do_spin(4'd5, 3, 1'b0, 1'b0);

        set_code_all(4'd3);
        do_spin(4'd15, 2, 1'b0, 1'b0);
        do_spin(4'd15, 2, 1'b0, 1'b0);
        bet_zero_test();

        v = 1234567890;
        for (int i = 0; i < 10; i++) begin
            code[i] = 4'(v % 10);
            v = v / 10;
        end
        repeat (3) do_spin(4'd5, 1, 1'b0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 10; i++) code[i] = 4'($urandom_range(0, 2));
            do_spin(4'($urandom_range(1, 15)), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Abort a spin with reset in its third SPIN cycle.
        set_code_all(4'd7);
        bet  = 4'd4;
        roll = 1'b1;
        e    = cyc + 1;
        sb.push_back('{e + 1, 1'b0, 8'd0, "abort_clear"});
        wait_cyc(e + 3);
        check("abort_in_spin", int'(dut.state), int'(SPIN));
        rst  = 1'b0;
        roll = 1'b0;
        #1;
        check("abort_jackpot", int'(jackpot), 0);
        check("abort_payout", int'(payout), 0);
        check("abort_state", int'(dut.state), int'(IDLE));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        last_jp  = 1'b0;
        last_pay = 8'd0;
        repeat (N + 6) @(negedge clk);
        check("abort_no_pay_state", int'(dut.state), int'(IDLE));
        check("abort_no_pay_jackpot", int'(jackpot), 0);
        check("abort_no_pay_payout", int'(payout), 0);

        // Roll high across reset release counts as a fresh rise.
        rst  = 1'b0;
        roll = 1'b1;
        set_code_all(4'd6);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        do_spin(4'd9, 1, 1'b0, 1'b0);

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
